// File: rtl/auto_transistor_pkg.sv
// rtl/auto_transistor_pkg.sv - state encodings and default timing for the auto-transistor driver
package auto_transistor_pkg;

  // State codes are visible on state_out and shared with the signal generator bench.
  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_ON        = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam int DEF_PWM_PERIOD  = 100;
  localparam int DEF_DUTY_STEP   = 10;
  localparam int DEF_STEP_CYCLES = 1000;
  localparam int DEF_DEAD_CYCLES = 500;

  // Duty must be able to hold the full value PWM_PERIOD, hence period+1 codes.
  function automatic int duty_width(input int period);
    return $clog2(period + 1);
  endfunction

endpackage

// File: rtl/auto_transistor_driver_if.sv
// rtl/auto_transistor_driver_if.sv - command/status bundle between controller and gate driver
// master: drives signal_in/fault_in/fault_clr, observes gate/duty/state/fault/on_count
// slave : the driver itself
interface auto_transistor_driver_if #(
  parameter int DUTY_W = 7
);
  logic              signal_in;
  logic              fault_in;
  logic              fault_clr;
  logic              gate_out;
  logic [DUTY_W-1:0] duty_out;
  logic [2:0]        state_out;
  logic              fault_latched;
  logic [15:0]       on_count;

  modport master (
    output signal_in, fault_in, fault_clr,
    input  gate_out, duty_out, state_out, fault_latched, on_count
  );

  modport slave (
    input  signal_in, fault_in, fault_clr,
    output gate_out, duty_out, state_out, fault_latched, on_count
  );
endinterface

// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - free-running PWM counter and registered gate compare
// Ports: clk, rst_n (sync active-low), duty (0..PWM_PERIOD), force_off (gate low next edge),
//        gate_out (registered gate drive)
module pwm_core #(
  parameter int PWM_PERIOD = 100,
  parameter int DUTY_W     = $clog2(PWM_PERIOD + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty,
  input  logic              force_off,
  output logic              gate_out
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);

  // Counter shares the duty width so the compare needs no extension;
  // duty == PWM_PERIOD then keeps the gate high for every count value.
  logic [DUTY_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      gate_out <= 1'b0;
    end else begin
      pwm_cnt  <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
      gate_out <= (pwm_cnt < duty) && !force_off;
    end
  end

endmodule

// File: rtl/auto_transistor_driver.sv
// rtl/auto_transistor_driver.sv - soft-start/soft-stop transistor gate driver with dead time and fault latch
// Ports: clk (system clock), rst_n (sync active-low), bus (slave modport):
//   signal_in (async on/off command), fault_in, fault_clr (clk-synchronous),
//   gate_out, duty_out, state_out, fault_latched, on_count (16-bit wrapping ON entry count)
module auto_transistor_driver
  import auto_transistor_pkg::*;
#(
  parameter int PWM_PERIOD  = DEF_PWM_PERIOD,
  parameter int DUTY_STEP   = DEF_DUTY_STEP,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  auto_transistor_driver_if.slave  bus
);

  localparam int DUTY_W = duty_width(PWM_PERIOD);
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int DEAD_W = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

  localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(PWM_PERIOD);
  localparam logic [DUTY_W:0]   STEP_WIDE = (DUTY_W + 1)'(DUTY_STEP);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEAD_CYCLES);

  logic              sync_q1, sig_s;
  state_t            state, state_d;
  logic [DUTY_W-1:0] duty, duty_d;
  logic [STEP_W-1:0] step_cnt, step_d;
  logic [DEAD_W-1:0] dead_cnt, dead_d;
  logic [15:0]       on_count, on_count_d;

  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W-1:0] duty_up, duty_dn;
  logic              step_done;

  // Two-flop synchroniser for the command coming from the slow generator domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sig_s   <= 1'b0;
    end else begin
      sync_q1 <= bus.signal_in;
      sig_s   <= sync_q1;
    end
  end

  // Saturating ramp arithmetic; one bit of headroom keeps the up-sum from wrapping
  // when DUTY_STEP does not divide PWM_PERIOD.
  always_comb begin
    up_sum    = {1'b0, duty} + STEP_WIDE;
    duty_up   = (up_sum >= {1'b0, DUTY_MAX}) ? DUTY_MAX : up_sum[DUTY_W-1:0];
    duty_dn   = ({1'b0, duty} <= STEP_WIDE) ? '0 : duty - STEP_WIDE[DUTY_W-1:0];
    step_done = (step_cnt == STEP_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_OFF;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty     <= '0;
      step_cnt <= '0;
      dead_cnt <= '0;
      on_count <= '0;
    end else begin
      duty     <= duty_d;
      step_cnt <= step_d;
      dead_cnt <= dead_d;
      on_count <= on_count_d;
    end
  end

  always_comb begin
    state_d    = state;
    duty_d     = duty;
    step_d     = step_cnt;
    dead_d     = dead_cnt;
    on_count_d = on_count;

    // A fault overrides every other transition, including command changes.
    if (bus.fault_in) begin
      state_d = ST_FAULT;
      duty_d  = '0;
    end else begin
      case (state)
        ST_OFF: begin
          duty_d = '0;
          if (dead_cnt != '0) dead_d = dead_cnt - 1'b1;
          if (sig_s && (dead_cnt == '0)) begin
            state_d = ST_RAMP_UP;
            step_d  = '0;
          end
        end

        ST_RAMP_UP: begin
          if (!sig_s) begin
            // Reversal keeps the present duty and restarts the step interval.
            state_d = ST_RAMP_DOWN;
            step_d  = '0;
          end else if (step_done) begin
            step_d = '0;
            duty_d = duty_up;
            if (duty_up == DUTY_MAX) begin
              state_d    = ST_ON;
              on_count_d = on_count + 16'd1;
            end
          end else begin
            step_d = step_cnt + 1'b1;
          end
        end

        ST_ON: begin
          duty_d = DUTY_MAX;
          if (!sig_s) begin
            state_d = ST_RAMP_DOWN;
            step_d  = '0;
          end
        end

        ST_RAMP_DOWN: begin
          if (sig_s) begin
            state_d = ST_RAMP_UP;
            step_d  = '0;
          end else if (step_done) begin
            step_d = '0;
            duty_d = duty_dn;
            if (duty_dn == '0) begin
              state_d = ST_OFF;
              dead_d  = DEAD_INIT;
            end
          end else begin
            step_d = step_cnt + 1'b1;
          end
        end

        ST_FAULT: begin
          duty_d = '0;
          // fault_in is known low on this path, so a clear is honoured here.
          if (bus.fault_clr) begin
            state_d = ST_OFF;
            dead_d  = DEAD_INIT;
          end
        end

        default: begin
          state_d = ST_OFF;
          duty_d  = '0;
        end
      endcase
    end
  end

  // Forcing from the next state drops the gate on the same edge that enters FAULT,
  // without waiting for the registered duty to reach zero.
  pwm_core #(
    .PWM_PERIOD (PWM_PERIOD),
    .DUTY_W     (DUTY_W)
  ) u_pwm_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .duty      (duty),
    .force_off (state_d == ST_FAULT),
    .gate_out  (bus.gate_out)
  );

  assign bus.duty_out      = duty;
  assign bus.state_out     = state;
  assign bus.fault_latched = (state == ST_FAULT);
  assign bus.on_count      = on_count;

endmodule

// File: tb/tb_auto_transistor_driver.sv
// tb/tb_auto_transistor_driver.sv - directed and randomized check of auto_transistor_driver against a reference model
module tb_auto_transistor_driver;

  localparam int P    = 8;
  localparam int DS   = 2;
  localparam int SC   = 4;
  localparam int DEAD = 6;

  logic clk = 1'b0;
  logic rst_n;

  int vectors     = 0;
  int miscompares = 0;

  auto_transistor_driver_if #(.DUTY_W(4)) bus ();

  auto_transistor_driver #(
    .PWM_PERIOD  (P),
    .DUTY_STEP   (DS),
    .STEP_CYCLES (SC),
    .DEAD_CYCLES (DEAD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: 0=off 1=ramp up 2=on 3=ramp down 4=fault.
  int m_s1, m_ss, m_mode, m_duty, m_step, m_dead, m_on, m_phase, m_gate;

  task automatic model_reset();
    m_s1 = 0; m_ss = 0; m_mode = 0; m_duty = 0; m_step = 0;
    m_dead = 0; m_on = 0; m_phase = 0; m_gate = 0;
  endtask

  task automatic model_clock();
    int n_mode, n_duty, n_step, n_dead, n_on, target;
    bit blocked;
    if (!rst_n) begin
      model_reset();
      return;
    end
    n_mode = m_mode; n_duty = m_duty; n_step = m_step; n_dead = m_dead; n_on = m_on;
    if (bus.fault_in) begin
      n_mode = 4; n_duty = 0;
    end else if (m_mode == 4) begin
      n_duty = 0;
      if (bus.fault_clr) begin n_mode = 0; n_dead = DEAD; end
    end else if (m_mode == 0) begin
      n_duty = 0;
      n_dead = (m_dead > 0) ? m_dead - 1 : 0;
      if (m_ss == 1 && m_dead == 0) begin n_mode = 1; n_step = 0; end
    end else if (m_mode == 2) begin
      n_duty = P;
      if (m_ss == 0) begin n_mode = 3; n_step = 0; end
    end else begin
      // Ramping: wanted direction follows the synchronised command.
      if ((m_mode == 1) != (m_ss == 1)) begin
        n_mode = (m_ss == 1) ? 1 : 3; n_step = 0;
      end else if (m_step == SC - 1) begin
        n_step = 0;
        target = (m_mode == 1) ? m_duty + DS : m_duty - DS;
        if (target > P) target = P;
        if (target < 0) target = 0;
        n_duty = target;
        if (target == P && m_mode == 1) begin n_mode = 2; n_on = (m_on + 1) % 65536; end
        if (target == 0 && m_mode == 3) begin n_mode = 0; n_dead = DEAD; end
      end else begin
        n_step = m_step + 1;
      end
    end
    blocked = (n_mode == 4);
    m_gate  = (m_phase < m_duty && !blocked) ? 1 : 0;
    m_phase = (m_phase + 1) % P;
    m_ss = m_s1; m_s1 = bus.signal_in ? 1 : 0;
    m_mode = n_mode; m_duty = n_duty; m_step = n_step; m_dead = n_dead; m_on = n_on;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    logic [31:0] e;
    e = expv;
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
    end
  endtask

  task automatic check_all();
    chk("state_out", 32'(bus.state_out), m_mode);
    chk("duty_out", 32'(bus.duty_out), m_duty);
    chk("gate_out", 32'(bus.gate_out), m_gate);
    chk("fault_latched", 32'(bus.fault_latched), (m_mode == 4) ? 1 : 0);
    chk("on_count", 32'(bus.on_count), m_on);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_state(input int st, input int bound, input string tag);
    int n = 0;
    while (bus.state_out !== 3'(st) && n < bound) begin tick(); n++; end
    chk(tag, 32'(bus.state_out), st);
  endtask

  task automatic wait_duty(input int d, input int bound, input string tag);
    int n = 0;
    while (bus.duty_out !== 4'(d) && n < bound) begin tick(); n++; end
    chk(tag, 32'(bus.duty_out), d);
  endtask

  initial begin
    int cnt;
    int fault_hold;
    rst_n = 1'b0;
    bus.signal_in = 1'b0;
    bus.fault_in  = 1'b0;
    bus.fault_clr = 1'b0;
    model_reset();
    @(negedge clk);

    // 1. reset held three clocks
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_state", 32'(bus.state_out), 0);
    chk("reset_duty", 32'(bus.duty_out), 0);
    chk("reset_on_count", 32'(bus.on_count), 0);

    // 2. command on: state changes 3 clocks after the input edge, then full ramp
    bus.signal_in = 1'b1;
    tick(); tick();
    chk("sync_not_yet", 32'(bus.state_out), 0);
    tick();
    chk("sync_ramp_up", 32'(bus.state_out), 1);
    wait_state(2, 40, "reach_on");
    chk("on_count_first", 32'(bus.on_count), 1);
    chk("on_duty_full", 32'(bus.duty_out), P);
    cnt = 0;
    repeat (8) begin tick(); cnt += int'(bus.gate_out); end
    chk("on_gate_constant", cnt, 8);

    // 3. hold duty at 4 by reversing faster than a step interval
    bus.signal_in = 1'b0;
    wait_duty(4, 40, "ramp_down_to_4");
    repeat (4) begin
      bus.signal_in = ~bus.signal_in; tick(); tick();
    end
    cnt = 0;
    repeat (8) begin
      bus.signal_in = ~bus.signal_in;
      tick(); cnt += int'(bus.gate_out);
      tick(); cnt += int'(bus.gate_out);
    end
    chk("duty4_gate_count", cnt, 8);
    chk("duty4_held", 32'(bus.duty_out), 4);

    // 4. ramp down to OFF, immediate re-request waits out the dead time
    bus.signal_in = 1'b0;
    wait_state(0, 60, "ramp_down_off");
    bus.signal_in = 1'b1;
    cnt = 1;
    for (int i = 0; i < 30 && bus.state_out === 3'd0; i++) begin
      tick();
      if (bus.state_out === 3'd0) cnt++;
    end
    chk("dead_off_samples", cnt, 7);
    chk("after_dead_ramp_up", 32'(bus.state_out), 1);

    // 5. fault in ON, ignored clear while fault active, then clean clear
    wait_state(2, 40, "reach_on_again");
    bus.fault_in = 1'b1;
    tick();
    chk("fault_gate", 32'(bus.gate_out), 0);
    chk("fault_state", 32'(bus.state_out), 4);
    chk("fault_latched", 32'(bus.fault_latched), 1);
    bus.fault_clr = 1'b1;
    tick(); tick();
    chk("fault_clr_ignored", 32'(bus.state_out), 4);
    bus.fault_in = 1'b0;
    tick();
    chk("fault_cleared", 32'(bus.state_out), 0);
    bus.fault_clr = 1'b0;
    cnt = 1;
    for (int i = 0; i < 30 && bus.state_out === 3'd0; i++) begin
      tick();
      if (bus.state_out === 3'd0) cnt++;
    end
    chk("fault_dead_samples", cnt, 7);

    // 6. reset in the middle of a ramp
    wait_duty(6, 40, "ramp_to_6");
    rst_n = 1'b0;
    tick();
    chk("midreset_state", 32'(bus.state_out), 0);
    chk("midreset_duty", 32'(bus.duty_out), 0);
    chk("midreset_gate", 32'(bus.gate_out), 0);
    chk("midreset_on_count", 32'(bus.on_count), 0);
    rst_n = 1'b1;

    // Randomized operation against the model
    fault_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(11) == 0) bus.signal_in = ~bus.signal_in;
      if (fault_hold > 0) begin
        fault_hold--;
      end else if ($urandom_range(149) == 0) begin
        fault_hold = $urandom_range(4, 1);
      end
      bus.fault_in  = (fault_hold > 0);
      bus.fault_clr = ($urandom_range(3) == 0);
      rst_n = ($urandom_range(499) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
